// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU control unit:
// state codes, opcodes, accumulator source selects.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD   = 4'd3,
        S_STORE  = 4'd4,
        S_ADD    = 4'd5,
        S_SUB    = 4'd6,
        S_INPUT  = 4'd7,
        S_JZ     = 4'd8,
        S_JPOS   = 4'd9,
        S_HALT   = 4'd10
    } state_e;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_IN    = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [1:0] ASEL_ALU = 2'b00;
    localparam logic [1:0] ASEL_IN  = 2'b01;
    localparam logic [1:0] ASEL_MEM = 2'b10;

    function automatic state_e exec_state(input logic [2:0] op);
        state_e s;
        case (op)
            OP_LOAD:  s = S_LOAD;
            OP_STORE: s = S_STORE;
            OP_ADD:   s = S_ADD;
            OP_SUB:   s = S_SUB;
            OP_IN:    s = S_INPUT;
            OP_JZ:    s = S_JZ;
            OP_JPOS:  s = S_JPOS;
            default:  s = S_HALT;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/inscyc_outdec.sv
// Control-line decoder: Moore outputs from the state code, qualified by the
// accumulator flags / Enter strobe in the INPUT, JZ and JPOS states.
module inscyc_outdec
    import cpu_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic       aeq0_i,
    input  logic       apos_i,
    input  logic       enter_i,
    output logic       irload_o,
    output logic       pcload_o,
    output logic       jmpmux_o,
    output logic       meminst_o,
    output logic       memwr_o,
    output logic [1:0] asel_o,
    output logic       aload_o,
    output logic       sub_o,
    output logic       halt_o
);

    always_comb begin
        irload_o  = 1'b0;
        pcload_o  = 1'b0;
        jmpmux_o  = 1'b0;
        meminst_o = 1'b0;
        memwr_o   = 1'b0;
        asel_o    = ASEL_ALU;
        aload_o   = 1'b0;
        sub_o     = 1'b0;
        halt_o    = 1'b0;
        case (state_i)
            S_FETCH: begin
                irload_o = 1'b1;
                pcload_o = 1'b1;
            end
            S_DECODE: meminst_o = 1'b1;
            S_LOAD: begin
                meminst_o = 1'b1;
                asel_o    = ASEL_MEM;
                aload_o   = 1'b1;
            end
            S_STORE: begin
                meminst_o = 1'b1;
                memwr_o   = 1'b1;
            end
            S_ADD: begin
                meminst_o = 1'b1;
                aload_o   = 1'b1;
            end
            S_SUB: begin
                meminst_o = 1'b1;
                aload_o   = 1'b1;
                sub_o     = 1'b1;
            end
            S_INPUT: begin
                asel_o  = ASEL_IN;
                aload_o = enter_i;
            end
            // Each branch looks only at its own flag.
            S_JZ: begin
                jmpmux_o = 1'b1;
                pcload_o = aeq0_i;
            end
            S_JPOS: begin
                jmpmux_o = 1'b1;
                pcload_o = apos_i;
            end
            S_HALT: halt_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/inscyc_ctrl.sv
// Instruction-cycle control FSM: FETCH -> DECODE -> EXECUTE, with HALT parking
// the machine until reset.
module inscyc_ctrl
    import cpu_pkg::*;
#(
    parameter int OPW = 3,
    parameter int SW  = 4
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic [OPW-1:0] IR,
    input  logic           Aeq0,
    input  logic           Apos,
    input  logic           Enter,
    output logic           IRload,
    output logic           PCload,
    output logic           JMPmux,
    output logic           Meminst,
    output logic           MemWr,
    output logic [1:0]     Asel,
    output logic           Aload,
    output logic           Sub,
    output logic           Halt,
    output logic [SW-1:0]  State
);

    state_e     state_q, state_d;
    logic [2:0] op;

    assign op    = IR[OPW-1 -: 3];
    assign State = SW'(state_q);

    // Outputs decode from state_q, so an async reset clears MemWr/Aload at once.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state_q <= S_START;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_START;
        case (state_q)
            S_START:  state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = exec_state(op);
            S_LOAD, S_STORE, S_ADD, S_SUB, S_JZ, S_JPOS:
                      state_d = S_FETCH;
            S_INPUT:  state_d = Enter ? S_FETCH : S_INPUT;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_START;
        endcase
    end

    inscyc_outdec u_outdec (
        .state_i   (state_q),
        .aeq0_i    (Aeq0),
        .apos_i    (Apos),
        .enter_i   (Enter),
        .irload_o  (IRload),
        .pcload_o  (PCload),
        .jmpmux_o  (JMPmux),
        .meminst_o (Meminst),
        .memwr_o   (MemWr),
        .asel_o    (Asel),
        .aload_o   (Aload),
        .sub_o     (Sub),
        .halt_o    (Halt)
    );

endmodule
